seg_bus_monitor: RTL and testbench

Receive-side reader for the 12-bit multiplexed seven-segment output bus driven by the display encoders (bits 0-6 segments a..g, bit 7 decimal point, bits 8-11 digit enables 1..4, all active-low). Samples the bus and waits for each digit pattern to settle. Decodes settled patterns back to 4-bit hex codes and keeps a per-digit shadow register of what the display currently shows. Used for on-board self-check and test benches of the display path.

---
 rtl/seg_bus_monitor.sv | 148 ++++++++++++++
 tb/tb_seg_bus_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_bus_monitor.sv
// Seven-segment bus reader: debounces each multiplexed digit, decodes it back to hex
// and keeps a per-digit shadow with freshness timers and sticky error flags.
module seg_bus_monitor #(
    parameter int STABLE_CYCLES   = 4,
    parameter int REFRESH_TIMEOUT = 1024,
    parameter int CNT_W           = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] segs_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic        capture_stb,
    output logic [1:0]  capture_idx,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_collision
);
    typedef enum logic [1:0] {TRACK, EVAL, HOLD} state_t;

    state_t           state;
    logic [11:0]      sample;
    logic [11:0]      prev_sample;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] timer [4];
    logic [3:0]       seen;

    logic             changed;
    logic [3:0]       en;
    logic [2:0]       en_cnt;
    logic [1:0]       en_idx;
    logic [6:0]       seg_on;
    logic             blank;
    logic             legal;
    logic [3:0]       code;
    logic [3:0]       seen_base;
    logic [CNT_W-1:0] cnt_inc;

    // EVAL looks at prev_sample: it always holds the settled pattern, while sample
    // may already carry the next bus value.
    always_comb begin
        changed   = sample != prev_sample;
        en        = ~prev_sample[11:8];
        en_cnt    = 3'(en[0]) + 3'(en[1]) + 3'(en[2]) + 3'(en[3]);
        en_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) en_idx = 2'(i);
        end
        seg_on    = ~prev_sample[6:0];
        blank     = seg_on == 7'h00;
        legal     = 1'b1;
        code      = 4'h0;
        case (seg_on)
            7'h3F: code = 4'h0;
            7'h06: code = 4'h1;
            7'h5B: code = 4'h2;
            7'h4F: code = 4'h3;
            7'h66: code = 4'h4;
            7'h6D: code = 4'h5;
            7'h7D: code = 4'h6;
            7'h07: code = 4'h7;
            7'h7F: code = 4'h8;
            7'h6F: code = 4'h9;
            7'h77: code = 4'hA;
            7'h7C: code = 4'hB;
            7'h39: code = 4'hC;
            7'h5E: code = 4'hD;
            7'h79: code = 4'hE;
            7'h71: code = 4'hF;
            default: legal = 1'b0;
        endcase
        seen_base = (seen == 4'hF) ? 4'h0 : seen;
        cnt_inc   = changed ? CNT_W'(1) : stable_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= TRACK;
            sample        <= '1;
            prev_sample   <= '1;
            stable_cnt    <= '0;
            digits        <= '0;
            dp            <= '0;
            digit_valid   <= '0;
            capture_stb   <= 1'b0;
            capture_idx   <= 2'd0;
            frame_done    <= 1'b0;
            err_pattern   <= 1'b0;
            err_collision <= 1'b0;
            seen          <= '0;
            for (int i = 0; i < 4; i++) timer[i] <= '0;
        end else begin
            sample      <= segs_in;
            prev_sample <= sample;
            capture_stb <= 1'b0;
            frame_done  <= seen == 4'hF;
            seen        <= seen_base;

            for (int i = 0; i < 4; i++) begin
                if (timer[i] == CNT_W'(1)) digit_valid[i] <= 1'b0;
                if (timer[i] != '0) timer[i] <= timer[i] - CNT_W'(1);
            end

            // EVAL actions come after the timer loop so a capture beats a same-cycle expiry.
            case (state)
                TRACK: begin
                    stable_cnt <= cnt_inc;
                    if (cnt_inc == CNT_W'(STABLE_CYCLES)) state <= EVAL;
                end
                EVAL: begin
                    if (en_cnt > 3'd1) begin
                        err_collision <= 1'b1;
                    end else if (en_cnt == 3'd1) begin
                        if (blank) begin
                            digit_valid[en_idx] <= 1'b0;
                        end else if (!legal) begin
                            err_pattern         <= 1'b1;
                            digit_valid[en_idx] <= 1'b0;
                        end else begin
                            digits[{en_idx, 2'b00} +: 4] <= code;
                            dp[en_idx]                   <= ~prev_sample[7];
                            digit_valid[en_idx]          <= 1'b1;
                            capture_stb                  <= 1'b1;
                            capture_idx                  <= en_idx;
                            seen                         <= seen_base | (4'b0001 << en_idx);
                            timer[en_idx]                <= CNT_W'(REFRESH_TIMEOUT);
                        end
                    end
                    // A bus change landing on the EVAL cycle must not be lost in HOLD.
                    if (changed) begin
                        stable_cnt <= CNT_W'(1);
                        state      <= TRACK;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        stable_cnt <= CNT_W'(1);
                        state      <= TRACK;
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_bus_monitor.sv
// Scoreboard bench for seg_bus_monitor: directed bus patterns queue expected captures,
// a negedge monitor pops them whenever capture_stb or frame_done fires.
module tb_seg_bus_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] segs_in;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic        capture_stb;
    logic [1:0]  capture_idx;
    logic        frame_done;
    logic        err_pattern;
    logic        err_collision;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t_cap;

    typedef struct {
        int idx;
        int val;
        int dpv;
        int at;
    } cap_t;

    cap_t cap_q[$];
    int   frame_q[$];
    cap_t mc;
    int   mf;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_bus_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .segs_in       (segs_in),
        .digits        (digits),
        .dp            (dp),
        .digit_valid   (digit_valid),
        .capture_stb   (capture_stb),
        .capture_idx   (capture_idx),
        .frame_done    (frame_done),
        .err_pattern   (err_pattern),
        .err_collision (err_collision)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] mk(input int k, input logic [6:0] g, input logic dpon);
        logic [3:0] en;
        en = ~(4'b0001 << k);
        return {en, ~dpon, ~g};
    endfunction

    // Pattern p appears on the bus at negedge n; a legal single-digit capture strobes at n+6.
    task automatic apply(input logic [11:0] p, input int hold, input bit exp_cap, input int k,
                         input int val, input bit dpon, input bit exp_frame);
        cap_t c;
        @(negedge clk);
        segs_in = p;
        if (exp_cap) begin
            c.idx = k; c.val = val; c.dpv = int'(dpon); c.at = cyc + 6;
            cap_q.push_back(c);
        end
        if (exp_frame) frame_q.push_back(cyc + 7);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        segs_in = 12'hFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digits"}, digits, 0);
        chk({tag, "_dp"}, dp, 0);
        chk({tag, "_valid"}, digit_valid, 0);
        chk({tag, "_stb"}, capture_stb, 0);
        chk({tag, "_idx"}, capture_idx, 0);
        chk({tag, "_frame"}, frame_done, 0);
        chk({tag, "_err_pattern"}, err_pattern, 0);
        chk({tag, "_err_collision"}, err_collision, 0);
    endtask

    always @(negedge clk) begin
        if (capture_stb) begin
            if (cap_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_capture: idx=%0d at cycle %0d, none expected", capture_idx, cyc);
            end else begin
                mc = cap_q.pop_front();
                chk("cap_idx", capture_idx, mc.idx);
                chk("cap_digit", digits[4*mc.idx +: 4], mc.val);
                chk("cap_dp", dp[mc.idx], mc.dpv);
                chk("cap_valid", digit_valid[mc.idx], 1);
                chk("cap_cycle", cyc, mc.at);
            end
        end
        if (frame_done) begin
            if (frame_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_frame_done: cycle %0d, none expected", cyc);
            end else begin
                mf = frame_q.pop_front();
                chk("frame_cycle", cyc, mf);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        segs_in = 12'hFFF;
        do_reset();
        check_zero("reset");

        // Single static digit: exactly one capture while held.
        apply(12'h7F9, 20, 1'b1, 3, 1, 1'b0, 1'b0);
        chk("static_valid", digit_valid, 4'b1000);
        chk("static_digit4", digits[15:12], 1);

        // Full frame of four digits.
        do_reset();
        apply(mk(0, glyph[2], 1'b0), 6, 1'b1, 0, 2, 1'b0, 1'b0);
        apply(mk(1, glyph[5], 1'b1), 6, 1'b1, 1, 5, 1'b1, 1'b0);
        apply(mk(2, glyph[10], 1'b0), 6, 1'b1, 2, 10, 1'b0, 1'b0);
        apply(mk(3, glyph[15], 1'b0), 6, 1'b1, 3, 15, 1'b0, 1'b1);
        apply(12'hFFF, 4, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("frame_digits", digits, 16'hFA52);
        chk("frame_dp", dp, 4'b0010);
        chk("frame_valid", digit_valid, 4'b1111);

        // Glitching bus never settles long enough.
        for (int i = 0; i < 6; i++)
            apply(mk(0, glyph[(i % 2 == 1) ? 7 : 3], 1'b0), 3, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(12'hFFF, 10, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("glitch_digits", digits, 16'hFA52);

        // Two enables low together.
        apply(12'h3C0, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(12'hFFF, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("collision_flag", err_collision, 1);
        chk("collision_digits", digits, 16'hFA52);
        chk("collision_no_pattern_err", err_pattern, 0);

        // Illegal glyph, then blank on a valid digit.
        apply(mk(0, 7'h49, 1'b0), 8, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(12'hFFF, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("illegal_flag", err_pattern, 1);
        chk("illegal_valid", digit_valid, 4'b1110);
        chk("illegal_digits", digits, 16'hFA52);
        apply(mk(1, 7'h00, 1'b0), 8, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(12'hFFF, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("blank_valid", digit_valid, 4'b1100);
        chk("blank_err_pattern", err_pattern, 1);
        chk("blank_err_collision", err_collision, 1);
        chk("blank_digits", digits, 16'hFA52);

        // Refresh timeout on digit 3.
        apply(mk(2, glyph[6], 1'b1), 6, 1'b1, 2, 6, 1'b1, 1'b0);
        t_cap = cyc + 1;
        @(negedge clk);
        segs_in = 12'hFFF;
        while (cyc < t_cap + 1023) @(negedge clk);
        chk("timeout_before", digit_valid[2], 1);
        @(negedge clk);
        chk("timeout_at", digit_valid[2], 0);
        chk("timeout_digit_kept", digits[11:8], 6);
        chk("timeout_dp_kept", dp[2], 1);

        // Reset while a refresh timer is mid-count.
        apply(mk(2, glyph[9], 1'b0), 6, 1'b1, 2, 9, 1'b0, 1'b0);
        @(negedge clk);
        segs_in = 12'hFFF;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_zero("postreset");

        chk("cap_queue_drained", cap_q.size(), 0);
        chk("frame_queue_drained", frame_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
